// File: rtl/exp_seq_pkg.sv
// Shared constants for the exponent-engine request sequencer: state codes and default widths.
package exp_seq_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] CLR     = 3'd1;
    localparam logic [STATE_W-1:0] GO      = 3'd2;
    localparam logic [STATE_W-1:0] WAIT    = 3'd3;
    localparam logic [STATE_W-1:0] PRESENT = 3'd4;
    localparam logic [STATE_W-1:0] ERR     = 3'd5;

    localparam int A_W_DEF     = 8;
    localparam int N_W_DEF     = 4;
    localparam int R_W_DEF     = 16;
    localparam int TIMEOUT_DEF = 1024;
    localparam int CNT_W_DEF   = $clog2(TIMEOUT_DEF);

    function automatic logic is_result_state(input logic [STATE_W-1:0] s);
        return (s == PRESENT) || (s == ERR);
    endfunction

endpackage

// File: rtl/exp_request_sequencer_rise_detect.sv
// One-cycle rising-edge detector; with START_SYNC_EN defined the input first
// passes through a 2-flop synchronizer.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_s;
    logic sig_q;

`ifdef START_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], sig};
        end
    end

    assign sig_s = sync_q[1];
`else
    assign sig_s = sig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_q;

endmodule

// File: rtl/exp_request_sequencer.sv
// Initiator side of the exponent engine go/done handshake, with result hand-off
// to the LCD path and a WAIT watchdog. Optional START_SYNC_EN synchronizes start/done.
module exp_request_sequencer
    import exp_seq_pkg::*;
#(
    parameter int A_W     = A_W_DEF,
    parameter int N_W     = N_W_DEF,
    parameter int R_W     = R_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [A_W-1:0]     a_i,
    input  logic [N_W-1:0]     n_i,
    output logic               eng_rst_n_o,
    output logic               go_o,
    output logic [A_W-1:0]     a_o,
    output logic [N_W-1:0]     n_o,
    input  logic               done_i,
    input  logic [R_W-1:0]     result_i,
    output logic [R_W-1:0]     result_o,
    output logic               result_valid_o,
    output logic               err_o,
    input  logic               lcd_ack_i,
    output logic               busy_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt;
    logic               start_rise;
    logic               done_rise;
    logic               timed_out;

    rise_detect u_start_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (start_i),
        .rise (start_rise)
    );

    rise_detect u_done_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (done_i),
        .rise (done_rise)
    );

    assign timed_out = (cnt == CNT_LAST);

    // A done edge in the final WAIT cycle beats the watchdog.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:         if (start_rise) state_next = CLR;
            CLR:          state_next = GO;
            GO:           state_next = WAIT;
            WAIT: begin
                if (done_rise) begin
                    state_next = PRESENT;
                end else if (timed_out) begin
                    state_next = ERR;
                end
            end
            PRESENT, ERR: if (lcd_ack_i) state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Engine controls are registered from the next state so they line up with CLR/GO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_rst_n_o <= 1'b0;
            go_o        <= 1'b0;
        end else begin
            eng_rst_n_o <= (state_next != CLR);
            go_o        <= (state_next == GO);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_o <= '0;
            n_o <= '0;
        end else if ((state == IDLE) && start_rise) begin
            a_o <= a_i;
            n_o <= n_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == GO) begin
            cnt <= '0;
        end else if (state == WAIT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_o <= '0;
            err_o    <= 1'b0;
        end else if (state == WAIT) begin
            if (done_rise) begin
                result_o <= result_i;
                err_o    <= 1'b0;
            end else if (timed_out) begin
                result_o <= '0;
                err_o    <= 1'b1;
            end
        end
    end

    assign result_valid_o = is_result_state(state);
    assign busy_o         = (state != IDLE);
    assign state_o        = state;

endmodule
